// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: control-bus bundle between the instruction sequencer and the CPU datapath
interface instr_sequencer_if #(
  parameter int ID_W   = 5,
  parameter int AMID_W = 2
);
  logic              hlt;
  logic [7:0]        ir0;
  logic [3:0]        alu_status;
  logic [ID_W-1:0]   mid;
  logic [ID_W-1:0]   sid;
  logic              mid_en;
  logic              sid_en;
  logic [AMID_W-1:0] amid;
  logic              pc_inr;
  logic [4:0]        alu_opcode;
  logic [7:0]        T;
  logic              halted;
  modport master (
    input  hlt, ir0, alu_status,
    output mid, sid, mid_en, sid_en, amid, pc_inr, alu_opcode, T, halted
  );
  modport slave (
    output hlt, ir0, alu_status,
    input  mid, sid, mid_en, sid_en, amid, pc_inr, alu_opcode, T, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute step FSM driving the CPU control bus from IR0 and the zero flag
module instr_sequencer #(
  parameter int ID_W   = 5,
  parameter int AMID_W = 2,
  parameter int Z_BIT  = 0
) (
  input logic clk,
  input logic reset,
  instr_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH, EX1, EX2, EX3, EX4, PAUSED, HALTED} state_e;
  state_e     state_q, state_d;
  logic       taken_q, taken_d;
  logic [2:0] cls;
  logic       jmp, done, en, pc, am;
  logic [4:0] m, s;
  always_ff @(posedge clk) begin
    state_q <= reset ? FETCH : state_d;
    taken_q <= reset ? 1'b0 : taken_d;
  end
  always_comb begin
    cls     = bus.ir0[7:5];
    taken_d = (state_q == EX1) ? bus.alu_status[Z_BIT] : taken_q;
    // JZ taken behaves exactly like JMP from EX1 onward
    jmp     = (cls == 3'd5) || (cls == 3'd6 && taken_d);
    state_d = state_q;
    done    = 1'b0;
    en      = 1'b0;
    pc      = 1'b0;
    am      = 1'b0;
    m       = 5'd0;
    s       = 5'd0;
    case (state_q)
      FETCH: begin
        state_d = EX1;
        en      = 1'b1;
        pc      = 1'b1;
        m       = 5'd4;
      end
      EX1: begin
        state_d = (cls == 3'd7) ? HALTED : EX2;
        done    = cls <= 3'd3;
        en      = (cls != 3'd0 && cls <= 3'd4) || jmp;
        pc      = cls inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        m       = (cls == 3'd3) ? 5'd18 : 5'd4;
        s       = (cls == 3'd1 || cls == 3'd3) ? 5'd2 : (cls == 3'd2) ? 5'd3 : 5'd7;
      end
      EX2: begin
        state_d = EX3;
        done    = cls == 3'd6 && !taken_q;
        en      = cls == 3'd4 || jmp;
        pc      = 1'b1;
        m       = 5'd4;
        s       = 5'd8;
      end
      EX3: begin
        state_d = EX4;
        done    = cls == 3'd4;
        en      = 1'b1;
        am      = cls == 3'd4;
        m       = (cls == 3'd4) ? 5'd2 : 5'd7;
        s       = (cls == 3'd4) ? 5'd4 : 5'd9;
      end
      EX4: begin
        done = 1'b1;
        en   = 1'b1;
        m    = 5'd8;
        s    = 5'd10;
      end
      PAUSED:  state_d = bus.hlt ? PAUSED : FETCH;
      default: state_d = HALTED;
    endcase
    // pause is only honoured at the instruction boundary
    if (done) state_d = bus.hlt ? PAUSED : FETCH;
  end
  assign bus.mid_en     = en && !reset;
  assign bus.sid_en     = en && !reset;
  assign bus.mid        = bus.mid_en ? ID_W'(m) : '0;
  assign bus.sid        = bus.sid_en ? ID_W'(s) : '0;
  assign bus.amid       = (am && !reset) ? AMID_W'(1) : '0;
  assign bus.pc_inr     = pc && !reset;
  assign bus.alu_opcode = bus.ir0[4:0];
  assign bus.T          = (reset || state_q > EX4) ? 8'd0 : 8'd1 << state_q;
  assign bus.halted     = state_q == HALTED && !reset;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: random instruction stream executed on a bench datapath and checked
// against an instruction-level model of PC, A, B, memory, latency and transfer counts
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  instr_sequencer_if #(.ID_W(5), .AMID_W(2)) bus ();
  instr_sequencer #(.ID_W(5), .AMID_W(2), .Z_BIT(0)) dut (.clk(clk), .reset(reset), .bus(bus));
  int          n_cmp = 0, n_bad = 0;
  int          n_en, n_pc, n_am;
  logic [7:0]  mem [256];
  logic [7:0]  mm [256];
  logic [7:0]  ir, a, b, ar0, ar1, m_a, m_b, lt;
  logic [15:0] pc, m_pc;
  logic        le, lp, lh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
    return op == 5'd0 ? x + y : op == 5'd1 ? x - y : x ^ y;
  endfunction

  // one clock: sample outputs before the edge, apply the transfer they request to the datapath
  task automatic cyc();
    logic [7:0] v, ad;
    #1;
    lt = bus.T;
    le = bus.mid_en;
    lp = bus.pc_inr;
    lh = bus.halted;
    chk("en_pair", 32'(bus.mid_en), 32'(bus.sid_en));
    chk("id_clash", 32'(bus.mid_en && bus.mid == bus.sid), 0);
    chk("amid_pcinr", 32'(bus.amid != 2'd0 && bus.pc_inr), 0);
    chk("alu_opcode", 32'(bus.alu_opcode), 32'(ir[4:0]));
    if (reset) begin
      chk("reset_out", 32'({bus.T, bus.mid_en, bus.sid_en, bus.pc_inr, bus.amid, bus.halted}), 0);
      pc = 16'd0;
    end else begin
      ad = (bus.amid == 2'd0) ? pc[7:0] : ar0;
      if (bus.mid_en) begin
        case (bus.mid)
          5'd0:    v = ir;
          5'd2:    v = a;
          5'd3:    v = b;
          5'd4:    v = mem[ad];
          5'd7:    v = ar0;
          5'd8:    v = ar1;
          5'd9:    v = pc[7:0];
          5'd10:   v = pc[15:8];
          5'd17:   v = {4'd0, bus.alu_status};
          5'd18:   v = alu_f(ir[4:0], a, b);
          default: v = 8'hxx;
        endcase
        case (bus.sid)
          5'd0:    ir = v;
          5'd2:    a = v;
          5'd3:    b = v;
          5'd4:    mem[ad] = v;
          5'd7:    ar0 = v;
          5'd8:    ar1 = v;
          5'd9:    pc[7:0] = v;
          5'd10:   pc[15:8] = v;
          default: ;
        endcase
        n_en++;
      end
      if (bus.amid != 2'd0) n_am++;
      if (bus.pc_inr) begin
        pc = pc + 16'd1;
        n_pc++;
      end
    end
    bus.ir0 = ir;
    @(negedge clk);
  endtask

  task automatic memchk(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  task automatic place(input logic [7:0] op, input logic [15:0] opd);
    logic [7:0] i;
    i = m_pc[7:0];
    mem[i] = op;
    mm[i] = op;
    i = i + 8'd1;
    mem[i] = opd[7:0];
    mm[i] = opd[7:0];
    i = i + 8'd1;
    mem[i] = opd[15:8];
    mm[i] = opd[15:8];
  endtask

  // hlt is high on steps hs <= k < he of the instruction
  task automatic run(input logic [7:0] op, input logic [15:0] opd, input logic z, input int hs, input int he);
    logic [2:0] c;
    logic       tk;
    logic [3:0] st;
    int         lat, e_en, e_pc;
    c    = op[7:5];
    tk   = c == 3'd5 || (c == 3'd6 && z);
    lat  = (c <= 3'd3 || c == 3'd7) ? 2 : (c == 3'd4) ? 4 : tk ? 5 : 3;
    e_en = (c == 3'd0 || c == 3'd7) ? 1 : (c <= 3'd3) ? 2 : (c == 3'd4) ? 4 : tk ? 5 : 1;
    e_pc = (c == 3'd0 || c == 3'd3 || c == 3'd7) ? 1 : (c <= 3'd2) ? 2 : 3;
    place(op, opd);
    st = 4'($urandom);
    st[0] = z;
    bus.alu_status = st;
    n_en = 0;
    n_pc = 0;
    n_am = 0;
    for (int k = 0; k < lat; k++) begin
      bus.hlt = k >= hs && k < he;
      if (k == 2) bus.alu_status = ~st;
      cyc();
      chk("step_T", 32'(lt), 32'(8'd1 << k));
    end
    m_pc = tk ? opd : m_pc + 16'(e_pc);
    if (c == 3'd1) m_a = opd[7:0];
    if (c == 3'd2) m_b = opd[7:0];
    if (c == 3'd3) m_a = alu_f(op[4:0], m_a, m_b);
    if (c == 3'd4) mm[opd[7:0]] = m_a;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("reg_a", 32'(a), 32'(m_a));
    chk("reg_b", 32'(b), 32'(m_b));
    memchk("mem");
    chk("n_xfer", n_en, e_en);
    chk("n_pcinr", n_pc, e_pc);
    chk("n_amid", n_am, 32'(c == 3'd4));
  endtask

  task automatic pause(input int n);
    for (int k = 0; k < n; k++) begin
      bus.hlt = k < n - 1;
      cyc();
      chk("paused", 32'({lt, le, lp}), 0);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
    m_pc = 16'd0;
  endtask

  initial begin
    int r, hs, he;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      mm[i] = mem[i];
    end
    ir = 8'd0; a = 8'd0; b = 8'd0; ar0 = 8'd0; ar1 = 8'd0;
    m_a = 8'd0; m_b = 8'd0; m_pc = 16'd0; pc = 16'd0;
    bus.hlt = 1'b0;
    bus.ir0 = 8'd0;
    bus.alu_status = 4'd0;
    @(negedge clk);
    do_reset(3);
    run(8'h20, 16'h0005, 1'b0, -1, 0);
    chk("lda_pc", 32'(pc), 32'h2);
    run(8'h40, 16'h0003, 1'b0, -1, 0);
    run(8'h60, 16'h0000, 1'b0, -1, 0);
    chk("add_a", 32'(a), 32'h08);
    run(8'h20, 16'h005A, 1'b0, -1, 0);
    run(8'h80, 16'h0040, 1'b0, -1, 0);
    chk("sta_m40", 32'(mem[8'h40]), 32'h5A);
    run(8'hC0, 16'h0010, 1'b1, -1, 0);
    chk("jz_taken_pc", 32'(pc), 32'h10);
    run(8'hC0, 16'h1234, 1'b0, -1, 0);
    chk("jz_not_pc", 32'(pc), 32'h13);
    run(8'hA0, 16'h0030, 1'b0, 2, 99);
    pause(3);
    run(8'h20, 16'h00C3, 1'b0, -1, 0);
    chk("after_pause_pc", 32'(pc), 32'h32);
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 3);
      hs = (r == 0) ? $urandom_range(0, 1) : (r == 1) ? 0 : -1;
      he = (r == 0) ? 99 : (r == 1) ? 1 : 0;
      run(8'($urandom_range(0, 8'hDF)), 16'($urandom), 1'($urandom), hs, he);
      if (bus.hlt) pause($urandom_range(1, 3));
    end
    run(8'hE0, 16'h0000, 1'b0, -1, 0);
    for (int k = 0; k < 6; k++) begin
      bus.hlt = k[0];
      cyc();
      chk("halted", 32'({lt, le, lp, lh}), 1);
    end
    bus.hlt = 1'b0;
    do_reset(2);
    mem[8'h77] = ~m_a;
    mm[8'h77] = ~m_a;
    place(8'h80, 16'h0077);
    cyc();
    chk("sta_fetch_T", 32'(lt), 1);
    cyc();
    chk("sta_ex1_T", 32'(lt), 2);
    do_reset(2);
    chk("reset_pc", 32'(pc), 0);
    memchk("reset_mem");
    for (int n = 0; n < 12; n++) run(8'($urandom_range(0, 8'hDF)), 16'($urandom), 1'($urandom), -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
